// File: rtl/binary_guess_game_ctrl.sv
// Binary-number guessing game controller: round timer, level tracking, LFSR target
// generator and guess comparator in one synchronous block.
module binary_guess_game_ctrl #(
  parameter int          NUM_W     = 4,
  parameter int          LEVEL_W   = 8,
  parameter int          TIME_W    = 5,
  parameter int          TICK_DIV  = 50_000_000,
  parameter int          BASE_TIME = 20,
  parameter int          TIME_STEP = 1,
  parameter int          MIN_TIME  = 5,
  parameter int          PENALTY   = 2,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               guess,
  input  logic [NUM_W-1:0]   switch,
  output logic [NUM_W-1:0]   target,
  output logic [LEVEL_W-1:0] level,
  output logic [TIME_W-1:0]  timeleft,
  output logic [2:0]         state,
  output logic               win,
  output logic               lose
);

  localparam int RW = TIME_W + LEVEL_W;
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    HIT  = 3'd3,
    OVER = 3'd4
  } state_t;

  state_t            cur_state;
  logic [15:0]       lfsr;
  logic [PW-1:0]     prescaler;
  logic              start_d;
  logic              guess_d;
  logic              start_e;
  logic              guess_e;
  logic              tick;
  logic              lfsr_fb;
  logic [NUM_W-1:0]  cand;
  logic [NUM_W-1:0]  next_target;
  logic [RW-1:0]     step_total;
  logic [RW-1:0]     round_wide;
  logic [TIME_W-1:0] round_time;
  logic [TIME_W-1:0] penalized;

  assign state   = cur_state;
  assign start_e = start & ~start_d;
  assign guess_e = guess & ~guess_d;
  assign tick    = (prescaler == PW'(TICK_DIV - 1));
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // A fresh candidate equal to the current target is bumped by one so rounds never repeat.
  assign cand        = lfsr[NUM_W-1:0];
  assign next_target = (cand == target) ? cand + NUM_W'(1) : cand;

  always_comb begin
    step_total = RW'(level) * RW'(TIME_STEP);
    round_wide = RW'(MIN_TIME);
    if (step_total < RW'(BASE_TIME)) begin
      if ((RW'(BASE_TIME) - step_total) > RW'(MIN_TIME)) begin
        round_wide = RW'(BASE_TIME) - step_total;
      end
    end
    round_time = round_wide[TIME_W-1:0];
    penalized  = (timeleft > TIME_W'(PENALTY)) ? timeleft - TIME_W'(PENALTY) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= IDLE;
      level     <= '0;
      timeleft  <= '0;
      target    <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
      lfsr      <= SEED;
      prescaler <= '0;
      start_d   <= 1'b0;
      guess_d   <= 1'b0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr_fb};
      start_d <= start;
      guess_d <= guess;
      win     <= 1'b0;
      lose    <= 1'b0;
      case (cur_state)
        IDLE: begin
          if (start_e) begin
            level     <= '0;
            cur_state <= LOAD;
          end
        end
        LOAD: begin
          target    <= next_target;
          timeleft  <= round_time;
          prescaler <= '0;
          cur_state <= PLAY;
        end
        PLAY: begin
          prescaler <= tick ? '0 : prescaler + PW'(1);
          // A correct guess wins even when the clock has just run out; a wrong one eats the tick.
          if (guess_e && (switch == target)) begin
            win       <= 1'b1;
            cur_state <= HIT;
          end else if (timeleft == '0) begin
            lose      <= 1'b1;
            cur_state <= OVER;
          end else if (guess_e) begin
            timeleft <= penalized;
          end else if (tick) begin
            timeleft <= timeleft - TIME_W'(1);
          end
        end
        HIT: begin
          if (!(&level)) begin
            level <= level + LEVEL_W'(1);
          end
          cur_state <= LOAD;
        end
        OVER: begin
          if (start_e) begin
            level     <= '0;
            cur_state <= LOAD;
          end
        end
        default: cur_state <= IDLE;
      endcase
    end
  end

endmodule
